jk_seq_ctrl: RTL
================

// Module: jk_seq_ctrl
// PURPOSE
//  Sequencer for a bank of WIDTH JK flip-flops (jk_cell instances). Accepts load/clear/count commands over a valid/ready
//  handshake and drives per-bit J/K: hold=00, set=10, reset=01, toggle=11.
//  Sits between a host/test controller and the JK register; q is the counter/state value used downstream.
// PARAMETERS
//  WIDTH      4      number of JK flip-flops in the bank (>=2)
// PORTS
//  clk        in   1      single clock, all state on posedge
//  rst        in   1      asynchronous, active-low reset (rst==0 resets immediately)
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      controller can accept a command (IDLE only)
//  cmd_op     in   2      00 COUNT_UP, 01 COUNT_DOWN, 10 LOAD, 11 CLEAR
//  cmd_data   in   WIDTH  LOAD value, or target value for COUNT_UP/COUNT_DOWN
//  hold       in   1      pause while counting (forces J=K=0)
//  j_o        out  WIDTH  J vector applied to bank this cycle (observability)
//  k_o        out  WIDTH  K vector applied to bank this cycle
//  q          out  WIDTH  JK bank outputs
//  busy       out  1      1 in UP/DOWN/DONE states
//  done       out  1      one-cycle pulse: count target reached
// BEHAVIOUR
//  - Reset (rst low, async): q=0, state=IDLE, cmd_ready=1, busy=0, done=0, j_o=k_o=0. Mid-count reset aborts, no done.
//  - States: IDLE, UP, DOWN, DONE. Accept = cmd_valid & cmd_ready (cycle N).
//  - IDLE: default J=K=0 (q holds). On accept:
//      LOAD : j_o=cmd_data, k_o=~cmd_data in cycle N; q==cmd_data at N+1; stay IDLE.
//      CLEAR: j_o=0, k_o=all-1 in cycle N; q==0 at N+1; stay IDLE.
//      UP/DOWN: latch cmd_data into target reg; -> UP / DOWN; no q change in cycle N.
//  - UP: if q==target -> DONE, J=K=0. Else if hold -> J=K=0. Else bit i: j=k=&q[i-1:0] (bit0 always toggles), q+1 mod 2^WIDTH.
//  - DOWN: same, bit i toggles when ~|q[i-1:0]; q-1 mod 2^WIDTH.
//  - Wrap-around legal: UP from q>target passes all-ones -> 0 -> target; DOWN symmetric through 0 -> all-ones.
//  - q==target at accept: one cycle in UP/DOWN, then DONE; q unchanged.
//  - DONE: done=1, J=K=0, cmd_ready=0; next cycle -> IDLE. done is decoded from state register (glitch-free, Moore).
//  - hold in IDLE/DONE: ignored. hold on cycle q==target: target check wins, -> DONE.
//  - cmd_valid while busy: not accepted, cmd_ready=0; host holds command stable until accepted.
//  - Latency: COUNT of distance D (mod 2^WIDTH) with no hold: done at cycle N+D+2, cmd_ready back at N+D+3.
//  - j_o/k_o combinational from state, q, cmd inputs; never J=K=1 on a bit outside UP/DOWN counting.
// STRUCTURE
//  - Package jk_seq_pkg: OP_UP/OP_DOWN/OP_LOAD/OP_CLEAR (2-bit) and state encoding S_IDLE/S_UP/S_DOWN/S_DONE.
//  - Sub-module jk_cell (clk, rst, j, k, q): one JK flip-flop, async active-low reset to 0, 00 hold/01 reset/10 set/11 toggle.
//    Generate-loop WIDTH instances. Controller FSM + J/K decode in this module.
// TESTING
//  1. Reset: rst low mid-UP count at q=5 -> q=0, busy=0, done=0, cmd_ready=1 same cycle, no done pulse afterwards.
//  2. LOAD 4'hA at cycle N -> j_o=1010,k_o=0101 at N; q=4'hA at N+1; cmd_ready stays 1; then CLEAR -> q=0 next cycle.
//  3. LOAD 2, COUNT_UP target 6 -> q 2,3,4,5,6 on successive cycles; done=1 for exactly one cycle after q first =6; q holds 6.
//  4. WIDTH=4, LOAD 14, COUNT_UP 1 -> q 14,15,0,1; done once. LOAD 1, COUNT_DOWN 14 -> 1,0,15,14; done once.
//  5. COUNT_UP 9 from 3 with hold high 3 cycles at q=5 -> q stays 5 for 3 cycles, j_o=k_o=0; done 3 cycles later than no-hold.
//  6. cmd_valid held with LOAD 7 during count -> not accepted while busy; accepted first IDLE cycle; COUNT_UP to current q -> done after 2 cycles, q unchanged.

Source files
------------

// File: rtl/jk_seq_pkg.sv
// Shared command and state encodings for the JK-bank sequencer.
package jk_seq_pkg;

  localparam logic [1:0] OP_UP    = 2'b00;
  localparam logic [1:0] OP_DOWN  = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_UP   = 2'b01,
    S_DOWN = 2'b10,
    S_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop: 00 hold, 01 reset, 10 set, 11 toggle; async active-low reset to 0.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_seq_ctrl.sv
// Command sequencer driving a bank of JK flip-flops: load, clear, and count up/down to a target.
module jk_seq_ctrl
  import jk_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             hold,
  output logic [WIDTH-1:0] j_o,
  output logic [WIDTH-1:0] k_o,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] up_tgl;
  logic [WIDTH-1:0] dn_tgl;
  logic             accept;
  logic             at_target;
  logic             is_count_op;

  // Status is Moore-decoded straight from the state register.
  assign cmd_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign accept      = cmd_valid & cmd_ready;
  assign at_target   = (q == target);
  assign is_count_op = (cmd_op == OP_UP) || (cmd_op == OP_DOWN);

  // Ripple toggle masks: a bit flips when all lower bits are 1 (up) or all 0 (down).
  always_comb begin
    up_tgl    = '0;
    dn_tgl    = '0;
    up_tgl[0] = 1'b1;
    dn_tgl[0] = 1'b1;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      up_tgl[i] = up_tgl[i-1] & q[i-1];
      dn_tgl[i] = dn_tgl[i-1] & ~q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      target <= '0;
    end else begin
      state <= state_nxt;
      if (accept && is_count_op) begin
        target <= cmd_data;
      end
    end
  end

  // Next state and J/K decode; J=K=1 only appears while actively counting.
  always_comb begin
    state_nxt = state;
    j_o       = '0;
    k_o       = '0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_LOAD: begin
              j_o = cmd_data;
              k_o = ~cmd_data;
            end
            OP_CLEAR: k_o = '1;
            OP_UP:    state_nxt = S_UP;
            default:  state_nxt = S_DOWN;
          endcase
        end
      end
      S_UP: begin
        if (at_target) begin
          state_nxt = S_DONE;
        end else if (!hold) begin
          j_o = up_tgl;
          k_o = up_tgl;
        end
      end
      S_DOWN: begin
        if (at_target) begin
          state_nxt = S_DONE;
        end else if (!hold) begin
          j_o = dn_tgl;
          k_o = dn_tgl;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (j_o[gi]),
      .k   (k_o[gi]),
      .q   (q[gi])
    );
  end

endmodule
